// File: rtl/sd_frame_tx_pkg.sv
// Shared types and constants for the SD line frame transmitter.
//  - state_e   : frame FSM states
//  - Crc7Poly  : x^7 + x^3 + 1 (implicit x^7 term dropped)
//  - Crc16Poly : x^16 + x^12 + x^5 + 1 (implicit x^16 term dropped)
//  - crc_poly(): selects the polynomial for a given CRC width
package sd_frame_tx_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StSbit,
        StPayload,
        StCrc,
        StEbit
    } state_e;

    localparam logic [6:0]  Crc7Poly  = 7'h09;
    localparam logic [15:0] Crc16Poly = 16'h1021;

    function automatic logic [15:0] crc_poly(input int unsigned width);
        return (width == 16) ? Crc16Poly : {9'd0, Crc7Poly};
    endfunction

endpackage

// File: rtl/sd_crc_lane.sv
// Serial CRC for one SD lane (CRC7 or CRC16, init 0).
// Ports:
//  clk_i, rst_ni : clock, asynchronous active-low reset
//  clr_i         : clear remainder to zero (highest priority)
//  in_en_i       : accumulate bit_i into the remainder
//  bit_i         : payload bit
//  shift_i       : shift the remainder left by one (zero fill) for transmission
//  msb_o         : current remainder MSB, i.e. the next CRC bit on the line
module sd_crc_lane
    import sd_frame_tx_pkg::*;
#(
    parameter int unsigned CrcWidth = 7
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clr_i,
    input  logic in_en_i,
    input  logic bit_i,
    input  logic shift_i,
    output logic msb_o
);

    localparam logic [CrcWidth-1:0] Poly = CrcWidth'(crc_poly(CrcWidth));

    logic [CrcWidth-1:0] crc_q, crc_d;
    logic                fb;

    always_comb begin
        crc_d = crc_q;
        fb    = 1'b0;
        if (clr_i) begin
            crc_d = '0;
        end else if (in_en_i) begin
            fb    = bit_i ^ crc_q[CrcWidth-1];
            crc_d = {crc_q[CrcWidth-2:0], 1'b0} ^ (fb ? Poly : '0);
        end else if (shift_i) begin
            crc_d = {crc_q[CrcWidth-2:0], 1'b0};
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            crc_q <= '0;
        end else begin
            crc_q <= crc_d;
        end
    end

    assign msb_o = crc_q[CrcWidth-1];

endmodule

// File: rtl/sd_frame_tx.sv
// SD line frame transmitter: start bit, streamed payload, per-lane CRC, end bit,
// on 1 lane (CMD / DAT0) or 4 lanes (DAT[3:0]).
// Ports:
//  clk_i, rst_ni        : system clock, asynchronous active-low reset
//  clk_en_p_i           : SD clock rising-edge enable; every FSM/shift step
//  clk_en_n_i           : SD clock falling-edge enable; output retiming
//  div_1_i              : SD clock equals clk_i; retime on negedge clk_i instead
//  start_i, len_bits_i  : frame request and payload length (accepted while idle)
//  abort_i              : cancel the frame in any state
//  word_i, word_valid_i, word_ready_o : payload word stream, MSB first
//  dat_o, dat_en_o      : retimed line data and tri-state enable
//  busy_o, done_o, underrun_o : status; done/underrun are 1-cycle pulses
// Build option SD_FRAME_TX_CRC_INJ_EN adds crc_inj_i: when set at accept, the lane 0
// CRC LSB is inverted on the line.
module sd_frame_tx
    import sd_frame_tx_pkg::*;
#(
    parameter int unsigned NumLanes  = 1,
    parameter int unsigned CrcWidth  = 7,
    parameter int unsigned WordWidth = 32,
    parameter int unsigned LenWidth  = 13
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 clk_en_p_i,
    input  logic                 clk_en_n_i,
    input  logic                 div_1_i,
    input  logic                 start_i,
    input  logic [LenWidth-1:0]  len_bits_i,
    input  logic                 abort_i,
`ifdef SD_FRAME_TX_CRC_INJ_EN
    input  logic                 crc_inj_i,
`endif
    input  logic [WordWidth-1:0] word_i,
    input  logic                 word_valid_i,
    output logic                 word_ready_o,
    output logic [NumLanes-1:0]  dat_o,
    output logic                 dat_en_o,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 underrun_o
);

    localparam int unsigned SlicesPerWord = WordWidth / NumLanes;
    localparam int unsigned SlW     = (SlicesPerWord > 1) ? $clog2(SlicesPerWord) : 1;
    localparam int unsigned CrcCntW = $clog2(CrcWidth);

    state_e               state_q, state_d;
    logic [LenWidth-1:0]  rem_q, rem_d;       // payload bits still to send, incl. current slice
    logic [WordWidth-1:0] shreg_q, shreg_d;
    logic [SlW-1:0]       slice_q, slice_d;   // slices left in current word after this one
    logic [CrcCntW-1:0]   crc_cnt_q, crc_cnt_d;
    logic                 inj_q, inj_d;
    logic                 done_q, done_d;
    logic                 underrun_q, underrun_d;

    logic                 crc_clr, crc_in_en, crc_shift;
    logic [NumLanes-1:0]  crc_msb;
    logic [NumLanes-1:0]  line_dat;
    logic                 line_en;
    logic                 last_slice, word_end;

    assign last_slice = (rem_q == LenWidth'(NumLanes));
    assign word_end   = (slice_q == '0);

    for (genvar l = 0; l < NumLanes; l++) begin : g_lane
        sd_crc_lane #(
            .CrcWidth (CrcWidth)
        ) u_crc (
            .clk_i   (clk_i),
            .rst_ni  (rst_ni),
            .clr_i   (crc_clr),
            .in_en_i (crc_in_en),
            .bit_i   (shreg_q[WordWidth-NumLanes+l]),
            .shift_i (crc_shift),
            .msb_o   (crc_msb[l])
        );
    end

    always_comb begin
        state_d      = state_q;
        rem_d        = rem_q;
        shreg_d      = shreg_q;
        slice_d      = slice_q;
        crc_cnt_d    = crc_cnt_q;
        inj_d        = inj_q;
        done_d       = 1'b0;
        underrun_d   = 1'b0;
        crc_clr      = 1'b0;
        crc_in_en    = 1'b0;
        crc_shift    = 1'b0;
        word_ready_o = 1'b0;
        line_dat     = '1;
        line_en      = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    state_d = StLoad;
                    rem_d   = len_bits_i;
                    crc_clr = 1'b1;
`ifdef SD_FRAME_TX_CRC_INJ_EN
                    inj_d   = crc_inj_i;
`else
                    inj_d   = 1'b0;
`endif
                end
            end
            StLoad: begin
                word_ready_o = clk_en_p_i;
                if (clk_en_p_i && word_valid_i) begin
                    shreg_d = word_i;
                    slice_d = SlW'(SlicesPerWord - 1);
                    state_d = StSbit;
                end
            end
            StSbit: begin
                line_dat = '0;
                line_en  = 1'b1;
                if (clk_en_p_i) begin
                    state_d = StPayload;
                end
            end
            StPayload: begin
                line_dat = shreg_q[WordWidth-1 -: NumLanes];
                line_en  = 1'b1;
                // The refill request shares the step that sends the word's last slice.
                if (word_end && !last_slice) begin
                    word_ready_o = clk_en_p_i;
                end
                if (clk_en_p_i) begin
                    crc_in_en = 1'b1;
                    rem_d     = rem_q - LenWidth'(NumLanes);
                    shreg_d   = shreg_q << NumLanes;
                    slice_d   = slice_q - SlW'(1);
                    if (last_slice) begin
                        state_d   = StCrc;
                        crc_cnt_d = '0;
                    end else if (word_end) begin
                        if (word_valid_i) begin
                            shreg_d = word_i;
                            slice_d = SlW'(SlicesPerWord - 1);
                        end else begin
                            underrun_d = 1'b1;
                            state_d    = StIdle;
                        end
                    end
                end
            end
            StCrc: begin
                line_dat    = crc_msb;
                line_dat[0] = crc_msb[0] ^ (inj_q && (crc_cnt_q == CrcCntW'(CrcWidth - 1)));
                line_en     = 1'b1;
                if (clk_en_p_i) begin
                    crc_shift = 1'b1;
                    crc_cnt_d = crc_cnt_q + CrcCntW'(1);
                    if (crc_cnt_q == CrcCntW'(CrcWidth - 1)) begin
                        state_d = StEbit;
                    end
                end
            end
            StEbit: begin
                line_en = 1'b1;
                if (clk_en_p_i) begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase

        // Abort overrides accept, completion and underrun alike.
        if (abort_i) begin
            state_d      = StIdle;
            done_d       = 1'b0;
            underrun_d   = 1'b0;
            word_ready_o = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= StIdle;
            rem_q      <= '0;
            shreg_q    <= '0;
            slice_q    <= '0;
            crc_cnt_q  <= '0;
            inj_q      <= 1'b0;
            done_q     <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            rem_q      <= rem_d;
            shreg_q    <= shreg_d;
            slice_q    <= slice_d;
            crc_cnt_q  <= crc_cnt_d;
            inj_q      <= inj_d;
            done_q     <= done_d;
            underrun_q <= underrun_d;
        end
    end

    // Output retiming: launch on the SD clock falling edge so the card sees stable
    // data at its rising edge. With div_1_i that edge is the falling edge of clk_i.
    logic [NumLanes-1:0] dat_neg_q, dat_pos_q;
    logic                en_neg_q, en_pos_q;

    always_ff @(negedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            dat_neg_q <= '1;
            en_neg_q  <= 1'b0;
        end else begin
            dat_neg_q <= line_dat;
            en_neg_q  <= line_en;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            dat_pos_q <= '1;
            en_pos_q  <= 1'b0;
        end else if (clk_en_n_i) begin
            dat_pos_q <= line_dat;
            en_pos_q  <= line_en;
        end
    end

    assign dat_o      = div_1_i ? dat_neg_q : dat_pos_q;
    assign dat_en_o   = div_1_i ? en_neg_q : en_pos_q;
    assign busy_o     = (state_q != StIdle);
    assign done_o     = done_q;
    assign underrun_o = underrun_q;

endmodule

// File: tb/tb_sd_frame_tx.sv
// Bench for sd_frame_tx: three instances (CMD: 1 lane CRC7 39-bit words; DAT: 1 lane
// CRC16; DAT: 4 lanes CRC16). Line bits are captured at each SD rising edge while
// the enable is high and compared with a reference frame built from the payload
// bit stream and CRCs computed by polynomial long division.
module tb_sd_frame_tx;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        clk_en_p, clk_en_n, div_1, abort;
    logic [2:0]  start_s;
    logic [12:0] len_s;
    logic [38:0] word_bus;
    logic        feed_valid;
    int          sel;

    logic       rdy0, rdy1, rdy2;
    logic       dat0, dat1;
    logic [3:0] dat2;
    logic       en0, en1, en2, busy0, busy1, busy2;
    logic       done0, done1, done2, und0, und1, und2;

    logic [3:0] cur_dat;
    logic       cur_en, cur_ready, cur_busy, cur_done, cur_und;

    logic [38:0] words_ref[$];
    logic [38:0] feed_q[$];
    logic [3:0]  cap_q[$];
    logic [3:0]  exp_q[$];
    int          done_cnt, und_cnt;
    int          n_vec = 0;
    int          n_err = 0;
    int          div_cnt = 0;
    bit          taken = 1'b0;

    always #5 clk_i = ~clk_i;

    sd_frame_tx #(.NumLanes(1), .CrcWidth(7), .WordWidth(39), .LenWidth(13)) u_cmd (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .clk_en_p_i   (clk_en_p),
        .clk_en_n_i   (clk_en_n),
        .div_1_i      (div_1),
        .start_i      (start_s[0]),
        .len_bits_i   (len_s),
        .abort_i      (abort),
`ifdef SD_FRAME_TX_CRC_INJ_EN
        .crc_inj_i    (1'b0),
`endif
        .word_i       (word_bus),
        .word_valid_i (feed_valid && sel == 0),
        .word_ready_o (rdy0),
        .dat_o        (dat0),
        .dat_en_o     (en0),
        .busy_o       (busy0),
        .done_o       (done0),
        .underrun_o   (und0)
    );

    sd_frame_tx #(.NumLanes(1), .CrcWidth(16), .WordWidth(32), .LenWidth(13)) u_dat1 (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .clk_en_p_i   (clk_en_p),
        .clk_en_n_i   (clk_en_n),
        .div_1_i      (div_1),
        .start_i      (start_s[1]),
        .len_bits_i   (len_s),
        .abort_i      (abort),
`ifdef SD_FRAME_TX_CRC_INJ_EN
        .crc_inj_i    (1'b0),
`endif
        .word_i       (word_bus[31:0]),
        .word_valid_i (feed_valid && sel == 1),
        .word_ready_o (rdy1),
        .dat_o        (dat1),
        .dat_en_o     (en1),
        .busy_o       (busy1),
        .done_o       (done1),
        .underrun_o   (und1)
    );

    sd_frame_tx #(.NumLanes(4), .CrcWidth(16), .WordWidth(32), .LenWidth(13)) u_dat4 (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .clk_en_p_i   (clk_en_p),
        .clk_en_n_i   (clk_en_n),
        .div_1_i      (div_1),
        .start_i      (start_s[2]),
        .len_bits_i   (len_s),
        .abort_i      (abort),
`ifdef SD_FRAME_TX_CRC_INJ_EN
        .crc_inj_i    (1'b0),
`endif
        .word_i       (word_bus[31:0]),
        .word_valid_i (feed_valid && sel == 2),
        .word_ready_o (rdy2),
        .dat_o        (dat2),
        .dat_en_o     (en2),
        .busy_o       (busy2),
        .done_o       (done2),
        .underrun_o   (und2)
    );

    always_comb begin
        cur_dat   = {3'b000, dat0};
        cur_en    = en0;
        cur_ready = rdy0;
        cur_busy  = busy0;
        cur_done  = done0;
        cur_und   = und0;
        if (sel == 1) begin
            cur_dat   = {3'b000, dat1};
            cur_en    = en1;
            cur_ready = rdy1;
            cur_busy  = busy1;
            cur_done  = done1;
            cur_und   = und1;
        end else if (sel == 2) begin
            cur_dat   = dat2;
            cur_en    = en2;
            cur_ready = rdy2;
            cur_busy  = busy2;
            cur_done  = done2;
            cur_und   = und2;
        end
    end

    // Sample one time unit before each rising clk_i edge.
    always @(negedge clk_i) begin
        #4;
        taken = feed_valid && cur_ready;
        if (cur_done) done_cnt++;
        if (cur_und) und_cnt++;
        if (clk_en_p && cur_en) cap_q.push_back(cur_dat);
    end

    // Drive enables and the word stream just after each rising edge.
    always @(posedge clk_i) begin
        #1;
        if (div_1) begin
            clk_en_p = 1'b1;
            clk_en_n = 1'b1;
        end else begin
            div_cnt  = (div_cnt + 1) % 4;
            clk_en_p = (div_cnt == 0);
            clk_en_n = (div_cnt == 2);
        end
        if (taken && feed_q.size() > 0) void'(feed_q.pop_front());
        feed_valid = (feed_q.size() > 0);
        word_bus   = feed_valid ? feed_q[0] : '0;
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] crc_div(input bit msg_in[$], input int crcw);
        bit          m[$];
        logic [16:0] g;
        logic [15:0] r;
        m = msg_in;
        g = (crcw == 7) ? 17'h00089 : 17'h11021;
        for (int k = 0; k < crcw; k++) m.push_back(1'b0);
        for (int i = 0; i < m.size() - crcw; i++) begin
            if (m[i]) begin
                for (int j = 0; j <= crcw; j++) m[i+j] = m[i+j] ^ g[crcw-j];
            end
        end
        r = '0;
        for (int k = 0; k < crcw; k++) r = {r[14:0], m[m.size()-crcw+k]};
        return r;
    endfunction

    function automatic void build_expect(input int lanes, input int crcw, input int ww,
                                         input int len);
        bit          stream[$];
        bit          lane_bits[$];
        logic [15:0] crc[4];
        logic [3:0]  v;
        foreach (words_ref[w]) begin
            for (int b = ww - 1; b >= 0; b--) begin
                if (stream.size() < len) stream.push_back(words_ref[w][b]);
            end
        end
        exp_q.delete();
        exp_q.push_back(4'h0);
        for (int s = 0; s < len / lanes; s++) begin
            v = '0;
            for (int l = 0; l < lanes; l++) v[l] = stream[s*lanes + lanes - 1 - l];
            exp_q.push_back(v);
        end
        for (int l = 0; l < lanes; l++) begin
            lane_bits.delete();
            for (int s = 0; s < len / lanes; s++) lane_bits.push_back(stream[s*lanes + lanes - 1 - l]);
            crc[l] = crc_div(lane_bits, crcw);
        end
        for (int k = crcw - 1; k >= 0; k--) begin
            v = '0;
            for (int l = 0; l < lanes; l++) v[l] = crc[l][k];
            exp_q.push_back(v);
        end
        exp_q.push_back(4'((1 << lanes) - 1));
    endfunction

    task automatic compare_frame(input string tag);
        check_eq({tag, "_steps"}, 64'(cap_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < cap_q.size() && i < exp_q.size(); i++) begin
            check_eq(tag, 64'(cap_q[i]), 64'(exp_q[i]));
        end
    endtask

    task automatic start_frame(input int inst, input int len);
        sel      = inst;
        cap_q.delete();
        done_cnt = 0;
        und_cnt  = 0;
        feed_q   = words_ref;
        @(posedge clk_i); #2;
        start_s[inst] = 1'b1;
        len_s         = 13'(len);
        @(posedge clk_i); #2;
        start_s = '0;
    endtask

    task automatic wait_end(input int budget);
        bit ended = 1'b0;
        for (int c = 0; c < budget; c++) begin
            @(posedge clk_i);
            if (done_cnt + und_cnt > 0) begin
                ended = 1'b1;
                break;
            end
        end
        repeat (10) @(posedge clk_i);
        check_eq("frame_end", 64'(ended), 64'd1);
    endtask

    task automatic run_frame(input int inst, input int len, input bit div1_mode);
        div_1 = div1_mode;
        repeat (4) @(posedge clk_i);
        start_frame(inst, len);
        wait_end(8 * (len + 40) + 100);
    endtask

    function automatic logic [63:0] pack_lane0();
        logic [63:0] v = '0;
        foreach (cap_q[i]) v = {v[62:0], cap_q[i][0]};
        return v;
    endfunction

    initial begin
        int lanes, crcw, ww, len, nw, inst;
        logic [15:0] crc16;

        rst_ni = 1'b0; clk_en_p = 1'b0; clk_en_n = 1'b0; div_1 = 1'b0; abort = 1'b0;
        start_s = '0; len_s = '0; word_bus = '0; feed_valid = 1'b0; sel = 2;
        done_cnt = 0; und_cnt = 0;
        repeat (3) @(posedge clk_i);
        #2;
        check_eq("rst_dat4", 64'(dat2), 64'hF);
        check_eq("rst_en4", 64'(en2), 64'd0);
        check_eq("rst_dat_cmd", 64'(dat0), 64'd1);
        check_eq("rst_en_cmd", 64'(en0), 64'd0);
        check_eq("rst_busy", 64'({busy0, busy1, busy2}), 64'd0);
        check_eq("rst_ready", 64'({rdy0, rdy1, rdy2}), 64'd0);
        check_eq("rst_pulses", 64'({done0, done1, done2, und0, und1, und2}), 64'd0);
        rst_ni = 1'b1;
        repeat (4) @(posedge clk_i);

        // CMD0 and CMD17 against known line patterns.
        words_ref = '{39'h40_0000_0000};
        run_frame(0, 39, 1'b0);
        check_eq("cmd0_line", pack_lane0(), 64'h4000_0000_0095);
        check_eq("cmd0_steps", 64'(cap_q.size()), 64'd48);
        check_eq("cmd0_done", 64'(done_cnt), 64'd1);
        check_eq("cmd0_busy", 64'(cur_busy), 64'd0);

        words_ref = '{39'h51_0000_0000};
        run_frame(0, 39, 1'b1);
        check_eq("cmd17_line", pack_lane0(), 64'h5100_0000_0055);
        check_eq("cmd17_done", 64'(done_cnt), 64'd1);

        // 4096 ones on one lane with CRC16.
        words_ref.delete();
        for (int i = 0; i < 128; i++) words_ref.push_back(39'hFFFF_FFFF);
        run_frame(1, 4096, 1'b1);
        crc16 = '0;
        for (int k = 0; k < 16 && 4097 + k < cap_q.size(); k++) crc16 = {crc16[14:0], cap_q[4097+k][0]};
        check_eq("ones_crc16", 64'(crc16), 64'h7FA1);
        check_eq("ones_end", (cap_q.size() == 4114) ? 64'(cap_q[4113]) : 64'hDEAD, 64'd1);
        build_expect(1, 16, 32, 4096);
        compare_frame("ones_frame");

        // Four lanes: nibble k of each word appears as slice value k.
        words_ref = '{39'h0123_4567, 39'h0123_4567};
        run_frame(2, 64, 1'b0);
        for (int k = 0; k < 16; k++) begin
            check_eq("nibble", (cap_q.size() > 1 + k) ? 64'(cap_q[1+k]) : 64'hDEAD, 64'(k % 8));
        end
        build_expect(4, 16, 32, 64);
        compare_frame("x4_frame");
        check_eq("x4_done", 64'(done_cnt), 64'd1);

        // Underrun: only 2 of 8 words ever become valid.
        words_ref = '{39'h1111_2222, 39'h3333_4444};
        run_frame(2, 256, 1'b0);
        check_eq("und_pulse", 64'(und_cnt), 64'd1);
        check_eq("und_done", 64'(done_cnt), 64'd0);
        check_eq("und_busy", 64'(cur_busy), 64'd0);
        check_eq("und_en", 64'(cur_en), 64'd0);
        check_eq("und_steps", 64'(cap_q.size()), 64'd17);

        // Abort mid-CRC, then a clean CMD0, in both retiming modes.
        for (int d = 0; d < 2; d++) begin
            div_1     = d[0];
            words_ref = '{39'h40_0000_0000};
            repeat (4) @(posedge clk_i);
            start_frame(0, 39);
            for (int c = 0; c < 2000 && cap_q.size() < 44; c++) @(posedge clk_i);
            check_eq("abort_reached", 64'(cap_q.size() >= 44), 64'd1);
            @(posedge clk_i); #2;
            abort = 1'b1;
            @(posedge clk_i); #2;
            abort = 1'b0;
            repeat (10) @(posedge clk_i);
            check_eq("abort_busy", 64'(cur_busy), 64'd0);
            check_eq("abort_dat", 64'(cur_dat), 64'd1);
            check_eq("abort_en", 64'(cur_en), 64'd0);
            check_eq("abort_done", 64'(done_cnt), 64'd0);
            run_frame(0, 39, d[0]);
            check_eq("post_abort_cmd0", pack_lane0(), 64'h4000_0000_0095);
        end

        // Randomized frames on all three configurations.
        for (int f = 0; f < 12; f++) begin
            inst  = $urandom_range(0, 2);
            lanes = (inst == 2) ? 4 : 1;
            crcw  = (inst == 0) ? 7 : 16;
            ww    = (inst == 0) ? 39 : 32;
            len   = lanes * $urandom_range(1, 100 / lanes);
            nw    = (len + ww - 1) / ww;
            words_ref.delete();
            for (int i = 0; i < nw; i++) words_ref.push_back({7'($urandom_range(0, 127)), $urandom()});
            run_frame(inst, len, 1'($urandom_range(0, 1)));
            build_expect(lanes, crcw, ww, len);
            compare_frame("rand_frame");
            check_eq("rand_done", 64'(done_cnt), 64'd1);
            check_eq("rand_und", 64'(und_cnt), 64'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
